abr_prim_sync_filter: RTL

//  Destination-domain capture stage for a quasi-static multi-bit signal arriving from another clock domain.

---
 rtl/abr_prim_cdc_pkg.sv | 10 +
 rtl/abr_prim_cdc_rand_delay.sv | 41 ++++
 rtl/abr_prim_flop_2sync.sv | 42 ++++
 rtl/abr_prim_sync_filter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/abr_prim_cdc_pkg.sv
// Shared CDC primitive types.
// Holds the state encoding of the synchronizer stability filter.
package abr_prim_cdc_pkg;

    typedef enum logic {
        SYNC_STABLE   = 1'b0,
        SYNC_SETTLING = 1'b1
    } abr_sync_filt_state_e;

endpackage

// File: rtl/abr_prim_cdc_rand_delay.sv
// Random-delay shim placed ahead of a synchronizer's first flop.
// When enabled it may hold the previous capture for one extra cycle to model a missed capture.
module abr_prim_cdc_rand_delay #(
    parameter int unsigned DataWidth = 1,
    parameter bit          Enable    = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_b,
    input  logic [DataWidth-1:0] prev_i,
    input  logic [DataWidth-1:0] src_i,
    output logic [DataWidth-1:0] data_o
);

    logic [7:0] lfsr_r;
    logic       held_r;
    logic       hold_s;

    // Decide whether to miss this capture; never twice in a row.
    always_comb begin
        hold_s = 1'b0;
        if (Enable && lfsr_r[0] && !held_r && (src_i != prev_i)) begin
            hold_s = 1'b1;
        end else begin
            hold_s = 1'b0;
        end
    end

    assign data_o = hold_s ? prev_i : src_i;

    // Pseudo-random source and one-extra-cycle limiter.
    always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            lfsr_r <= 8'hA5;
            held_r <= 1'b0;
        end else begin
            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
            held_r <= hold_s;
        end
    end

endmodule

// File: rtl/abr_prim_flop_2sync.sv
// Two-flop synchronizer with a random-delay shim in front of the first flop.
// Both flops reset to ResetValue so reset release produces no apparent edge.
module abr_prim_flop_2sync #(
    parameter int unsigned          DataWidth       = 1,
    parameter logic [DataWidth-1:0] ResetValue      = '0,
    parameter bit                   EnableRandDelay = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_b,
    input  logic [DataWidth-1:0] d_i,
    output logic [DataWidth-1:0] q_o
);

    logic [DataWidth-1:0] q1_r;
    logic [DataWidth-1:0] q2_r;
    logic [DataWidth-1:0] shim_s;

    abr_prim_cdc_rand_delay #(
        .DataWidth (DataWidth),
        .Enable    (EnableRandDelay)
    ) u_rand_delay (
        .clk_i  (clk_i),
        .rst_b  (rst_b),
        .prev_i (q1_r),
        .src_i  (d_i),
        .data_o (shim_s)
    );

    // Synchronizer chain.
    always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            q1_r <= ResetValue;
            q2_r <= ResetValue;
        end else begin
            q1_r <= shim_s;
            q2_r <= q1_r;
        end
    end

    assign q_o = q2_r;

endmodule

// File: rtl/abr_prim_sync_filter.sv
// Destination-domain capture of a quasi-static bus: 2-flop sync followed by a
// stability filter that commits a word only after StableCycles equal samples.
module abr_prim_sync_filter
    import abr_prim_cdc_pkg::*;
#(
    parameter int unsigned          DataWidth       = 1,
    parameter int                   StableCycles    = 2,
    parameter logic [DataWidth-1:0] ResetValue      = '0,
    parameter bit                   EnableRandDelay = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_b,
    input  logic [DataWidth-1:0] async_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 change_o,
    output logic                 glitch_o,
    output logic                 busy_o
);

    localparam int CntW = $clog2(StableCycles + 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(StableCycles - 1);

    if (StableCycles < 1) begin : gen_bad_cfg
        $fatal(1, "abr_prim_sync_filter: StableCycles must be >= 1");
    end

    abr_sync_filt_state_e state_r, state_s;
    logic [DataWidth-1:0] sync_s;
    logic [DataWidth-1:0] cand_r, cand_s;
    logic [DataWidth-1:0] data_r, data_s;
    logic [CntW-1:0]      cnt_r, cnt_s;
    logic                 change_r, change_s;
    logic                 glitch_r, glitch_s;
    logic                 busy_r;

    abr_prim_flop_2sync #(
        .DataWidth       (DataWidth),
        .ResetValue      (ResetValue),
        .EnableRandDelay (EnableRandDelay)
    ) u_sync (
        .clk_i (clk_i),
        .rst_b (rst_b),
        .d_i   (async_i),
        .q_o   (sync_s)
    );

    // Filter next-state: the whole word is one candidate, any bit change restarts it.
    always_comb begin
        state_s  = state_r;
        cand_s   = cand_r;
        cnt_s    = cnt_r;
        data_s   = data_r;
        change_s = 1'b0;
        glitch_s = 1'b0;
        case (state_r)
            SYNC_STABLE: begin
                if (sync_s != data_r) begin
                    if (StableCycles == 1) begin
                        data_s   = sync_s;
                        change_s = 1'b1;
                    end else begin
                        cand_s  = sync_s;
                        cnt_s   = CntOne;
                        state_s = SYNC_SETTLING;
                    end
                end else begin
                    state_s = SYNC_STABLE;
                end
            end
            SYNC_SETTLING: begin
                if (sync_s == cand_r) begin
                    if (cnt_r == CntLast) begin
                        data_s   = cand_r;
                        change_s = 1'b1;
                        cnt_s    = {CntW{1'b0}};
                        state_s  = SYNC_STABLE;
                    end else begin
                        cnt_s = cnt_r + CntOne;
                    end
                end else if (sync_s == data_r) begin
                    glitch_s = 1'b1;
                    cnt_s    = {CntW{1'b0}};
                    state_s  = SYNC_STABLE;
                end else begin
                    // New value while settling: drop the old candidate and restart.
                    glitch_s = 1'b1;
                    cand_s   = sync_s;
                    cnt_s    = CntOne;
                end
            end
            default: begin
                cnt_s   = {CntW{1'b0}};
                state_s = SYNC_STABLE;
            end
        endcase
    end

    // Filter state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
            state_r  <= SYNC_STABLE;
            cand_r   <= ResetValue;
            data_r   <= ResetValue;
            cnt_r    <= {CntW{1'b0}};
            change_r <= 1'b0;
            glitch_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cand_r   <= cand_s;
            data_r   <= data_s;
            cnt_r    <= cnt_s;
            change_r <= change_s;
            glitch_r <= glitch_s;
            busy_r   <= (state_s == SYNC_SETTLING);
        end
    end

    assign data_o   = data_r;
    assign change_o = change_r;
    assign glitch_o = glitch_r;
    assign busy_o   = busy_r;

endmodule
